// File: rtl/q_serializer_if.sv
// rtl/q_serializer_if.sv - request/pulse-train bundle between a charge source and q_serializer
interface q_serializer_if #(
  parameter int BUS_WIDTH = 10
);
  logic                 start;
  logic [BUS_WIDTH-1:0] q_in;
  logic                 q_serialized;
  logic                 busy;
  logic                 done;

  modport master (
    output start, q_in,
    input  q_serialized, busy, done
  );

  modport slave (
    input  start, q_in,
    output q_serialized, busy, done
  );
endinterface

// File: rtl/q_serializer.sv
// rtl/q_serializer.sv - turns a charge value into floor(q_in/Q_PER_PULSE) fixed-width pulses
// Define Q_SERIALIZER_ROUND_EN to round the pulse count half-up instead of truncating.
module q_serializer #(
  parameter int BUS_WIDTH      = 10,
  parameter int Q_PER_PULSE    = 30,
  parameter int PULSE_DURATION = 3,
  parameter int GAP_DURATION   = 2
) (
  input  logic           clk,
  input  logic           rst,
  q_serializer_if.slave  bus
);
  localparam int MAX_DUR = (PULSE_DURATION > GAP_DURATION) ? PULSE_DURATION : GAP_DURATION;
  localparam int CW      = (MAX_DUR > 1) ? $clog2(MAX_DUR) : 1;

  localparam logic [BUS_WIDTH-1:0] QP         = BUS_WIDTH'(Q_PER_PULSE);
  localparam logic [CW-1:0]        PULSE_LOAD = CW'(PULSE_DURATION - 1);
  localparam logic [CW-1:0]        GAP_LOAD   = CW'(GAP_DURATION - 1);

  typedef enum logic [1:0] {IDLE, HIGH, LOW, DONE} state_t;

  state_t               state;
  logic [BUS_WIDTH-1:0] rem;
  logic [CW-1:0]        cnt;
  logic                 qs_r;
  logic                 busy_r;
  logic                 done_r;

  // Decision point is shared by the accepting edge (uses q_in) and the end of a gap (uses rem).
  logic [BUS_WIDTH-1:0] src;
  logic                 take_full;
  logic                 take_pulse;
  logic [BUS_WIDTH-1:0] rem_after;

  assign src       = (state == IDLE) ? bus.q_in : rem;
  assign take_full = (src >= QP);

`ifdef Q_SERIALIZER_ROUND_EN
  localparam logic [BUS_WIDTH-1:0] QH = BUS_WIDTH'(Q_PER_PULSE / 2);
  logic take_round;
  assign take_round = (src != '0) && (src >= QH);
  assign take_pulse = take_full || take_round;
`else
  assign take_pulse = take_full;
`endif

  // A rounding pulse consumes whatever is left, so rem settles at zero.
  assign rem_after = take_full ? (src - QP) : '0;

  always_ff @(posedge clk) begin
    if (rst) begin
      state  <= IDLE;
      rem    <= '0;
      cnt    <= '0;
      qs_r   <= 1'b0;
      busy_r <= 1'b0;
      done_r <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (bus.start) begin
            busy_r <= 1'b1;
            if (take_pulse) begin
              state <= HIGH;
              rem   <= rem_after;
              cnt   <= PULSE_LOAD;
              qs_r  <= 1'b1;
            end else begin
              state  <= DONE;
              rem    <= bus.q_in;
              cnt    <= '0;
              done_r <= 1'b1;
            end
          end
        end
        HIGH: begin
          if (cnt == '0) begin
            state <= LOW;
            cnt   <= GAP_LOAD;
            qs_r  <= 1'b0;
          end else begin
            cnt <= cnt - 1'b1;
          end
        end
        LOW: begin
          if (cnt == '0) begin
            if (take_pulse) begin
              state <= HIGH;
              rem   <= rem_after;
              cnt   <= PULSE_LOAD;
              qs_r  <= 1'b1;
            end else begin
              state  <= DONE;
              cnt    <= '0;
              done_r <= 1'b1;
            end
          end else begin
            cnt <= cnt - 1'b1;
          end
        end
        DONE: begin
          state  <= IDLE;
          cnt    <= '0;
          busy_r <= 1'b0;
          done_r <= 1'b0;
        end
        default: begin
          state  <= IDLE;
          cnt    <= '0;
          qs_r   <= 1'b0;
          busy_r <= 1'b0;
          done_r <= 1'b0;
        end
      endcase
    end
  end

  assign bus.q_serialized = qs_r;
  assign bus.busy         = busy_r;
  assign bus.done         = done_r;
endmodule

// File: tb/tb_q_serializer.sv
// tb/tb_q_serializer.sv - directed bench for q_serializer with default parameters
module tb_q_serializer;
  logic clk;
  logic rst;
  int   tests;
  int   fails;

  q_serializer_if #(.BUS_WIDTH(10)) bus ();

  q_serializer #(
    .BUS_WIDTH(10),
    .Q_PER_PULSE(30),
    .PULSE_DURATION(3),
    .GAP_DURATION(2)
  ) dut (
    .clk(clk),
    .rst(rst),
    .bus(bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic check(input string tag, input int obs, input int exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  function automatic int outs();
    return {29'd0, bus.q_serialized, bus.busy, bus.done};
  endfunction

  // Starts a transfer, counts rising edges of q_serialized until done, returns to IDLE.
  task automatic run_count(input int q, output int n);
    logic prev;
    logic seen;
    n    = 0;
    prev = 1'b0;
    seen = 1'b0;
    bus.start = 1'b1;
    bus.q_in  = 10'(q);
    tick();
    bus.start = 1'b0;
    for (int i = 0; i < 400; i++) begin
      if (bus.q_serialized && !prev) n++;
      prev = bus.q_serialized;
      if (bus.done) begin
        seen = 1'b1;
        break;
      end
      tick();
    end
    check("done_reached", int'(seen), 1);
    tick();
  endtask

  int n;
  int exp_v;

  initial begin
    tests     = 0;
    fails     = 0;
    rst       = 1'b1;
    bus.start = 1'b0;
    bus.q_in  = '0;
    tick();
    tick();
    check("reset_outs", outs(), 0);

    // q_in=95: pulses in cycles 1-3, 6-8, 11-13; done in 16; busy 1-16
    rst       = 1'b0;
    bus.start = 1'b1;
    bus.q_in  = 10'd95;
    tick();
    bus.start = 1'b0;
    for (int c = 1; c <= 18; c++) begin
      exp_v = 0;
      if ((c >= 1 && c <= 3) || (c >= 6 && c <= 8) || (c >= 11 && c <= 13)) exp_v += 4;
      if (c >= 1 && c <= 16) exp_v += 2;
      if (c == 16) exp_v += 1;
      check($sformatf("q95_cycle%0d", c), outs(), exp_v);
      tick();
    end

    // q_in=29: straight to DONE; start held through DONE is not accepted back-to-back
    bus.start = 1'b1;
    bus.q_in  = 10'd29;
    tick();
    check("q29_cycle1", outs(), 3);
    tick();
    check("q29_no_back_to_back", outs(), 0);
    tick();
    check("q29_accept_after_idle", outs(), 3);
    bus.start = 1'b0;
    tick();
    check("q29_idle", outs(), 0);

    run_count(80, n);
`ifdef Q_SERIALIZER_ROUND_EN
    check("q80_pulses", n, 3);
`else
    check("q80_pulses", n, 2);
`endif
    run_count(74, n);
    check("q74_pulses", n, 2);

    // q_in=60 with start held and q_in changed mid-transfer
    begin
      logic prev;
      logic seen;
      n    = 0;
      prev = 1'b0;
      seen = 1'b0;
      bus.start = 1'b1;
      bus.q_in  = 10'd60;
      tick();
      bus.q_in = 10'd1023;
      for (int i = 0; i < 400; i++) begin
        if (bus.q_serialized && !prev) n++;
        prev = bus.q_serialized;
        if (bus.done) begin
          seen = 1'b1;
          break;
        end
        tick();
      end
      bus.start = 1'b0;
      check("q60_done_reached", int'(seen), 1);
      check("q60_pulses", n, 2);
      tick();
      check("q60_idle_after", outs(), 0);
    end

    // reset in cycle 7 of a q_in=95 transfer, with start raised alongside
    bus.start = 1'b1;
    bus.q_in  = 10'd95;
    tick();
    bus.start = 1'b0;
    for (int c = 2; c <= 7; c++) tick();
    check("abort_cycle7_high", outs(), 6);
    rst       = 1'b1;
    bus.start = 1'b1;
    bus.q_in  = 10'd30;
    tick();
    check("abort_cycle8", outs(), 0);
    rst       = 1'b0;
    bus.start = 1'b0;
    for (int c = 9; c <= 20; c++) begin
      tick();
      check($sformatf("abort_quiet_cycle%0d", c), outs(), 0);
    end
    run_count(30, n);
    check("after_abort_q30_pulses", n, 1);

    // loopback measurement: 30 charge units per pulse
    run_count(0, n);
    check("meas_q0", n * 30, 0);
    run_count(30, n);
    check("meas_q30", n * 30, 30);
    run_count(300, n);
    check("meas_q300", n * 30, 300);
    run_count(1020, n);
    check("meas_q1020", n * 30, 1020);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule

// File: doc/q_serializer.md
Q_SERIALIZER -- requirements
Module: q_serializer

Interface
REQ-001 SHALL have parameter BUS_WIDTH, default 10: width of the charge bus.
REQ-002 SHALL have parameter Q_PER_PULSE, default 30: charge units represented by one emitted pulse; legal range 1 .. 2**BUS_WIDTH-1.
REQ-003 SHALL have parameter PULSE_DURATION, default 3: clock cycles q_serialized stays high per pulse; minimum 1.
REQ-004 SHALL have parameter GAP_DURATION, default 2: clock cycles q_serialized stays low after each pulse; minimum 1.
REQ-005 SHALL have port clk, input, 1 bit: single clock; all logic on its rising edge.
REQ-006 SHALL have port rst, input, 1 bit: reset, synchronous and active-high.
REQ-007 SHALL have port start, input, 1 bit: request to serialize q_in.
REQ-008 SHALL have port q_in, input, BUS_WIDTH bits: unsigned charge value to serialize.
REQ-009 SHALL have port q_serialized, output, 1 bit: registered pulse train, the line q_measurement counts.
REQ-010 SHALL have port busy, output, 1 bit: a transfer is in progress.
REQ-011 SHALL have port done, output, 1 bit: one-cycle end-of-transfer strobe.

Function
REQ-012 SHALL implement the FSM states IDLE, HIGH, LOW and DONE; busy = 1 in HIGH, LOW and DONE; done = 1 only in DONE; q_serialized = 1 only in HIGH.
REQ-013 SHALL, in IDLE with start=1 at edge k, latch q_in into a BUS_WIDTH-bit remainder register rem.
REQ-014 SHALL, at that edge k, go to HIGH with rem reduced by Q_PER_PULSE if q_in >= Q_PER_PULSE; otherwise go to DONE with no pulse.
REQ-015 SHALL hold HIGH for exactly PULSE_DURATION cycles, then go to LOW.
REQ-016 SHALL hold LOW for exactly GAP_DURATION cycles, then go to HIGH with rem reduced by Q_PER_PULSE if rem >= Q_PER_PULSE; otherwise go to DONE.
REQ-017 SHALL stay in DONE for exactly one cycle, then go to IDLE.
REQ-018 SHALL make the number of pulses equal floor(q_in / Q_PER_PULSE), computed by repeated subtraction with no divider; rem SHALL never underflow.
REQ-019 SHALL ignore start while busy=1; q_in SHALL be sampled only at the accepting edge, and later q_in changes SHALL have no effect.
REQ-020 SHALL accept a new start in the IDLE cycle immediately after DONE; no back-to-back acceptance from DONE.
REQ-021 SHALL use a duration counter wide enough for max(PULSE_DURATION, GAP_DURATION); the counter SHALL reload on every state entry.
REQ-022 SHALL produce glitch-free, registered outputs only.

Reset
REQ-023 SHALL, when rst=1 at a rising edge, set the state to IDLE and clear q_serialized, busy, done, rem and the duration counter to 0.
REQ-024 SHALL give rst priority over start in the same cycle; start is not accepted.
REQ-025 SHALL, on reset mid-transfer, drive q_serialized low from the next cycle, emit no done, and leave the aborted transfer unresumed.

Configuration
REQ-026 SHALL support the macro Q_SERIALIZER_ROUND_EN.
REQ-027 SHALL, with Q_SERIALIZER_ROUND_EN defined, emit one extra pulse at the point where REQ-014 or REQ-016 would go to DONE, if 0 < rem and rem >= Q_PER_PULSE/2 (integer division); rem then becomes 0, so the pulse count is round-half-up of q_in / Q_PER_PULSE.
REQ-028 SHALL, without Q_SERIALIZER_ROUND_EN, use truncating behaviour (REQ-018) and contain no rounding logic.

Verification
REQ-029 SHALL cover: rst, then q_in=95 and start pulsed at edge 0 (defaults) -> q_serialized high in cycles 1-3, 6-8 and 11-13, low otherwise; done=1 in cycle 16 only; busy=1 in cycles 1-16.
REQ-030 SHALL cover: q_in=29 with start -> no pulse; done=1 in cycle 1; busy=1 in cycle 1 only.
REQ-031 SHALL cover: q_in=80 -> 2 pulses without the macro; 3 pulses with Q_SERIALIZER_ROUND_EN (remainder 20 >= 15); q_in=74 -> 2 pulses in both builds.
REQ-032 SHALL cover: start reasserted and q_in changed to 1023 during a q_in=60 transfer -> exactly 2 pulses; the second start is ignored.
REQ-033 SHALL cover: rst asserted in cycle 7 of a q_in=95 transfer -> all outputs 0 from cycle 8; no done; a following start with q_in=30 yields exactly 1 pulse.
REQ-034 SHALL cover: loopback into q_measurement (same BUS_WIDTH and Q_PER_PULSE) for q_in = 0, 30, 300 and 1020 -> q_measured equals Q_PER_PULSE * pulse count.
